// File: rtl/mess_credit_controller_pkg.sv
// Shared codes for the multi-user mess credit controller: actions, response
// status, FSM state encoding and the per-action deduction lookup.
package mess_credit_pkg;

    typedef enum logic [1:0] {
        ACT_MEAL     = 2'b00,
        ACT_SPECIAL  = 2'b01,
        ACT_RECHARGE = 2'b10,
        ACT_QUERY    = 2'b11
    } action_e;

    typedef enum logic [1:0] {
        ST_OK        = 2'b00,
        ST_INSUFF    = 2'b01,
        ST_CLIPPED   = 2'b10,
        ST_BAD_USER  = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_EXEC   = 3'd2,
        S_RESP   = 3'd3,
        S_HOLD   = 3'd4
    } state_e;

    // Only MEAL and SPECIAL deduct; the caller decides whether the action
    // is a deduction at all.
    function automatic int deduct_cost(action_e act, int meal_cost, int special_cost);
        return (act == ACT_SPECIAL) ? special_cost : meal_cost;
    endfunction

endpackage

// File: rtl/mess_credit_controller_if.sv
// Request/response bus of the credit controller, plus the debug counters
// that travel with it.
interface mess_credit_controller_if #(
    parameter int UID_W = 2,
    parameter int BAL_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [UID_W-1:0] req_user;
    logic [1:0]       req_action;
    logic [BAL_W-1:0] req_amount;
    logic             resp_valid;
    logic [1:0]       resp_status;
    logic [UID_W-1:0] resp_user;
    logic [BAL_W-1:0] resp_balance;
    logic [15:0]      txn_count;
    logic [2:0]       state;

    modport master (
        output req_valid, req_user, req_action, req_amount,
        input  req_ready, resp_valid, resp_status, resp_user, resp_balance,
               txn_count, state
    );

    modport slave (
        input  req_valid, req_user, req_action, req_amount,
        output req_ready, resp_valid, resp_status, resp_user, resp_balance,
               txn_count, state
    );
endinterface

// File: rtl/mess_credit_controller_credit_bank.sv
// Balance register file: one combinational read port, one synchronous
// write port, every entry reset to INIT_BAL.
module credit_bank #(
    parameter int NUM_USERS = 4,
    parameter int UID_W     = 2,
    parameter int BAL_W     = 8,
    parameter int INIT_BAL  = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [UID_W-1:0] rd_addr_i,
    output logic [BAL_W-1:0] rd_data_o,
    input  logic             wr_en_i,
    input  logic [UID_W-1:0] wr_addr_i,
    input  logic [BAL_W-1:0] wr_data_i
);

    logic [BAL_W-1:0] mem_q [NUM_USERS];

    // Write port; addresses beyond NUM_USERS match no entry and are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_USERS; i++) begin
                mem_q[i] <= BAL_W'(INIT_BAL);
            end
        end else if (wr_en_i) begin
            for (int i = 0; i < NUM_USERS; i++) begin
                if (wr_addr_i == UID_W'(i)) begin
                    mem_q[i] <= wr_data_i;
                end
            end
        end
    end

    // Read port; an unmapped address reads as zero.
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < NUM_USERS; i++) begin
            if (rd_addr_i == UID_W'(i)) begin
                rd_data_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/mess_credit_controller.sv
// Multi-user mess credit controller: one transaction at a time through
// IDLE -> LOOKUP -> EXEC -> RESP -> (HOLD) -> IDLE.
//
//   state  | meaning
//   IDLE   | ready; accept request on valid
//   LOOKUP | load working balance from the bank
//   EXEC   | compute result/status, commit write
//   RESP   | one-cycle response strobe
//   HOLD   | HOLD_CYCLES idle cycles before next accept
module mess_credit_controller
    import mess_credit_pkg::*;
#(
    parameter int NUM_USERS    = 4,
    parameter int UID_W        = 2,
    parameter int BAL_W        = 8,
    parameter int INIT_BAL     = 100,
    parameter int MEAL_COST    = 30,
    parameter int SPECIAL_COST = 50,
    parameter int MAX_BAL      = 200,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    mess_credit_controller_if.slave  bus
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    state_e           state_q, state_d;
    logic [UID_W-1:0] user_q;
    action_e          action_q;
    logic [BAL_W-1:0] amount_q;
    logic             bad_q;
    logic [BAL_W-1:0] bal_q;
    logic [HOLD_W-1:0] hold_q;
    logic [15:0]      txn_q;
    status_e          resp_status_q;
    logic [UID_W-1:0] resp_user_q;
    logic [BAL_W-1:0] resp_balance_q;

    logic             accept;
    logic [BAL_W-1:0] rd_data;
    logic [BAL_W-1:0] cost;
    logic [BAL_W:0]   sum;
    status_e          exec_status;
    logic [BAL_W-1:0] exec_bal;
    logic             exec_wr;
    logic             bank_wr;

    assign accept  = bus.req_valid && (state_q == S_IDLE);
    assign bank_wr = (state_q == S_EXEC) && exec_wr;

    credit_bank #(
        .NUM_USERS (NUM_USERS),
        .UID_W     (UID_W),
        .BAL_W     (BAL_W),
        .INIT_BAL  (INIT_BAL)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_i (user_q),
        .rd_data_o (rd_data),
        .wr_en_i   (bank_wr),
        .wr_addr_i (user_q),
        .wr_data_i (exec_bal)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_LOOKUP;
            S_LOOKUP: state_d = S_EXEC;
            S_EXEC:   state_d = S_RESP;
            S_RESP:   state_d = (HOLD_CYCLES > 0) ? S_HOLD : S_IDLE;
            S_HOLD:   if (hold_q == HOLD_LAST) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs and registered response fields onto the bus.
    always_comb begin
        bus.req_ready    = (state_q == S_IDLE);
        bus.resp_valid   = (state_q == S_RESP);
        bus.resp_status  = resp_status_q;
        bus.resp_user    = resp_user_q;
        bus.resp_balance = resp_balance_q;
        bus.txn_count    = txn_q;
        bus.state        = state_q;
    end

    // Transaction arithmetic, evaluated on the working balance.
    always_comb begin
        exec_status = ST_OK;
        exec_bal    = bal_q;
        exec_wr     = 1'b0;
        cost        = BAL_W'(deduct_cost(action_q, MEAL_COST, SPECIAL_COST));
        sum         = {1'b0, bal_q} + {1'b0, amount_q};
        if (bad_q) begin
            exec_status = ST_BAD_USER;
            exec_bal    = '0;
        end else begin
            case (action_q)
                ACT_MEAL, ACT_SPECIAL: begin
                    if (bal_q >= cost) begin
                        exec_bal = bal_q - cost;
                        exec_wr  = 1'b1;
                    end else begin
                        exec_status = ST_INSUFF;
                    end
                end
                ACT_RECHARGE: begin
                    exec_wr = 1'b1;
                    if (sum > (BAL_W+1)'(MAX_BAL)) begin
                        exec_bal    = BAL_W'(MAX_BAL);
                        exec_status = ST_CLIPPED;
                    end else begin
                        exec_bal = sum[BAL_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Request capture, working balance, response fields and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            user_q         <= '0;
            action_q       <= ACT_MEAL;
            amount_q       <= '0;
            bad_q          <= 1'b0;
            bal_q          <= '0;
            hold_q         <= '0;
            txn_q          <= '0;
            resp_status_q  <= ST_OK;
            resp_user_q    <= '0;
            resp_balance_q <= '0;
        end else begin
            if (accept) begin
                user_q   <= bus.req_user;
                action_q <= action_e'(bus.req_action);
                amount_q <= bus.req_amount;
                bad_q    <= (int'(bus.req_user) >= NUM_USERS);
            end
            if (state_q == S_LOOKUP && !bad_q) begin
                bal_q <= rd_data;
            end
            if (state_q == S_EXEC) begin
                resp_status_q  <= exec_status;
                resp_user_q    <= user_q;
                resp_balance_q <= exec_bal;
                if (exec_wr) txn_q <= txn_q + 16'd1;
            end
            if (state_q == S_RESP) begin
                hold_q <= '0;
            end else if (state_q == S_HOLD) begin
                hold_q <= hold_q + HOLD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mess_credit_controller.sv
// Directed bench for mess_credit_controller: a default-parameter instance
// and a NUM_USERS=3 instance for the unmapped-user case.
module tb_mess_credit_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    always #5 clk = ~clk;

    mess_credit_controller_if #(.UID_W(2), .BAL_W(8)) ifa ();
    mess_credit_controller_if #(.UID_W(2), .BAL_W(8)) if3 ();

    mess_credit_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    mess_credit_controller #(.NUM_USERS(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Wait (bounded) until the selected instance is ready; ends on a negedge.
    task automatic wait_ready(input bit use3, input string tag);
        int n = 0;
        @(negedge clk);
        while (!(use3 ? if3.req_ready : ifa.req_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, use3 ? if3.req_ready : ifa.req_ready, 1);
    endtask

    // One full transaction; response checked in the 3rd cycle after accept.
    task automatic txn(input bit use3, input string tag, input logic [1:0] u,
                       input logic [1:0] act, input logic [7:0] amt,
                       input logic [1:0] es, input logic [7:0] eb, input logic [15:0] etx);
        wait_ready(use3, tag);
        if (use3) begin
            if3.req_valid = 1'b1; if3.req_user = u; if3.req_action = act; if3.req_amount = amt;
        end else begin
            ifa.req_valid = 1'b1; ifa.req_user = u; ifa.req_action = act; ifa.req_amount = amt;
        end
        @(negedge clk);
        if (use3) if3.req_valid = 1'b0; else ifa.req_valid = 1'b0;
        chk({tag, "_rv_c1"}, use3 ? if3.resp_valid : ifa.resp_valid, 0);
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_rv"},   use3 ? if3.resp_valid   : ifa.resp_valid,   1);
        chk({tag, "_st"},   use3 ? if3.resp_status  : ifa.resp_status,  es);
        chk({tag, "_usr"},  use3 ? if3.resp_user    : ifa.resp_user,    u);
        chk({tag, "_bal"},  use3 ? if3.resp_balance : ifa.resp_balance, eb);
        chk({tag, "_txn"},  use3 ? if3.txn_count    : ifa.txn_count,    etx);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_st[13] = '{0, 1, 2, 3, 4, 4, 0, 1, 2, 3, 4, 4, 0};
        ifa.req_valid = 1'b0; ifa.req_user = '0; ifa.req_action = '0; ifa.req_amount = '0;
        if3.req_valid = 1'b0; if3.req_user = '0; if3.req_action = '0; if3.req_amount = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_ready", ifa.req_ready, 1);
        chk("rst_rv",    ifa.resp_valid, 0);
        chk("rst_st",    ifa.resp_status, 0);
        chk("rst_usr",   ifa.resp_user, 0);
        chk("rst_bal",   ifa.resp_balance, 0);
        chk("rst_txn",   ifa.txn_count, 0);
        chk("rst_state", ifa.state, 0);
        rst = 1'b0;

        // T1
        txn(0, "t1_query_u2", 2'd2, 2'b11, 8'd0, 2'b00, 8'd100, 16'd0);

        // T2
        txn(0, "t2_meal1", 2'd1, 2'b00, 8'd0, 2'b00, 8'd70, 16'd1);
        txn(0, "t2_meal2", 2'd1, 2'b00, 8'd0, 2'b00, 8'd40, 16'd2);
        txn(0, "t2_meal3", 2'd1, 2'b00, 8'd0, 2'b00, 8'd10, 16'd3);
        txn(0, "t2_meal4", 2'd1, 2'b00, 8'd0, 2'b01, 8'd10, 16'd3);

        // T3
        txn(0, "t3_rech150", 2'd0, 2'b10, 8'd150, 2'b10, 8'd200, 16'd4);
        txn(0, "t3_special", 2'd0, 2'b01, 8'd0,   2'b00, 8'd150, 16'd5);
        txn(0, "t3_rech0",   2'd0, 2'b10, 8'd0,   2'b00, 8'd150, 16'd6);

        // Exact-cost deduction and recharge at the ceiling.
        txn(0, "bnd_spec_a", 2'd3, 2'b01, 8'd0,  2'b00, 8'd50,  16'd7);
        txn(0, "bnd_spec_b", 2'd3, 2'b01, 8'd0,  2'b00, 8'd0,   16'd8);
        txn(0, "bnd_to_max", 2'd0, 2'b10, 8'd50, 2'b00, 8'd200, 16'd9);
        txn(0, "bnd_at_max", 2'd0, 2'b10, 8'd1,  2'b10, 8'd200, 16'd10);

        // T4: valid held high; accepts every 6 cycles, late input changes ignored.
        wait_ready(0, "t4");
        ifa.req_valid = 1'b1; ifa.req_user = 2'd2; ifa.req_action = 2'b11; ifa.req_amount = 8'd0;
        for (int n = 0; n < 13; n++) begin
            chk($sformatf("t4_state_%0d", n), ifa.state, exp_st[n]);
            chk($sformatf("t4_ready_%0d", n), ifa.req_ready, (exp_st[n] == 0) ? 1 : 0);
            if (n == 1) begin
                ifa.req_user = 2'd1; ifa.req_action = 2'b10; ifa.req_amount = 8'd5;
            end
            if (n == 3) begin
                chk("t4_r1_rv",  ifa.resp_valid, 1);
                chk("t4_r1_usr", ifa.resp_user, 2);
                chk("t4_r1_bal", ifa.resp_balance, 100);
                chk("t4_r1_st",  ifa.resp_status, 0);
                chk("t4_r1_txn", ifa.txn_count, 10);
            end
            if (n == 9) begin
                chk("t4_r2_rv",  ifa.resp_valid, 1);
                chk("t4_r2_usr", ifa.resp_user, 1);
                chk("t4_r2_bal", ifa.resp_balance, 15);
                chk("t4_r2_st",  ifa.resp_status, 0);
                chk("t4_r2_txn", ifa.txn_count, 11);
            end
            if (n == 12) ifa.req_valid = 1'b0;
            else @(negedge clk);
        end

        // T5: unmapped user on the 3-user instance.
        txn(1, "t5_bad_meal", 2'd3, 2'b00, 8'd0,  2'b11, 8'd0,   16'd0);
        txn(1, "t5_bad_rech", 2'd3, 2'b10, 8'd50, 2'b11, 8'd0,   16'd0);
        txn(1, "t5_q_u0",     2'd0, 2'b11, 8'd0,  2'b00, 8'd100, 16'd0);
        txn(1, "t5_q_u1",     2'd1, 2'b11, 8'd0,  2'b00, 8'd100, 16'd0);
        txn(1, "t5_q_u2",     2'd2, 2'b11, 8'd0,  2'b00, 8'd100, 16'd0);

        // T6: reset asserted during EXEC of a MEAL on user 2.
        wait_ready(0, "t6");
        ifa.req_valid = 1'b1; ifa.req_user = 2'd2; ifa.req_action = 2'b00; ifa.req_amount = 8'd0;
        @(negedge clk);
        ifa.req_valid = 1'b0;
        @(negedge clk);
        chk("t6_in_exec", ifa.state, 2);
        rst = 1'b1;
        #1;
        chk("t6_state", ifa.state, 0);
        chk("t6_ready", ifa.req_ready, 1);
        chk("t6_rv",    ifa.resp_valid, 0);
        chk("t6_st",    ifa.resp_status, 0);
        chk("t6_usr",   ifa.resp_user, 0);
        chk("t6_bal",   ifa.resp_balance, 0);
        chk("t6_txn",   ifa.txn_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        txn(0, "t6_q_u2", 2'd2, 2'b11, 8'd0, 2'b00, 8'd100, 16'd0);
        txn(0, "t6_q_u1", 2'd1, 2'b11, 8'd0, 2'b00, 8'd100, 16'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mess_credit_controller.md
Name: mess_credit_controller

Overview:
Multi-user successor to the single-balance mess credit top level. It holds a bank of NUM_USERS credit balances and serves one transaction at a time over a valid/ready request port. Supported transactions are meal deduction, special-meal deduction, recharge and query. Each transaction passes through a sequential FSM with a programmable post-transaction hold, and each returns a one-cycle response carrying status and resulting balance.

Parameters:
NUM_USERS, 4, number of user accounts (>=2)
UID_W, 2, user-id width; 2^UID_W >= NUM_USERS
BAL_W, 8, balance and amount width
INIT_BAL, 100, balance loaded into every account on reset
MEAL_COST, 30, deduction for action MEAL
SPECIAL_COST, 50, deduction for action SPECIAL
MAX_BAL, 200, recharge ceiling; MAX_BAL <= 2^BAL_W-1
HOLD_CYCLES, 2, idle cycles after each response before the next accept (0 = none)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  controller can accept; high only in IDLE
req_user  in  UID_W  target account
req_action  in  2  00 MEAL, 01 SPECIAL, 10 RECHARGE, 11 QUERY
req_amount  in  BAL_W  recharge amount; ignored for other actions
resp_valid  out  1  one-cycle response strobe
resp_status  out  2  00 OK, 01 INSUFFICIENT, 10 CLIPPED, 11 BAD_USER
resp_user  out  UID_W  echo of the accepted user id
resp_balance  out  BAL_W  account balance after the transaction (0 on BAD_USER)
txn_count  out  16  count of committed writes, wraps at 2^16
state  out  3  current FSM state, for debug and display

Behaviour:
- Reset (async assert, sync release):
  - all balances = INIT_BAL; FSM = IDLE; req_ready = 1.
  - resp_valid = 0, resp_status = 00, resp_user = 0, resp_balance = 0, txn_count = 0, hold counter = 0.
- FSM states: IDLE(0), LOOKUP(1), EXEC(2), RESP(3), HOLD(4).
  - IDLE: accept on an edge with req_valid & req_ready. Capture user, action and amount, then go to LOOKUP.
  - LOOKUP: register bank[user] into the working balance, then go to EXEC.
  - EXEC: compute the result and status. Write the bank when the status is OK or CLIPPED and the action is not QUERY; txn_count += 1 on each write. Go to RESP.
  - RESP: resp_valid = 1 for exactly this cycle; response fields stay registered until the next RESP. Go to HOLD when HOLD_CYCLES > 0, else IDLE.
  - HOLD: counter runs 0..HOLD_CYCLES-1, then IDLE.
- Timing:
  - resp_valid is high in the 3rd cycle after the accept edge.
  - Accept-to-next-accept period = 4 + HOLD_CYCLES cycles.
- Handshake:
  - req_valid outside IDLE is ignored; there is no queuing.
  - Request inputs are sampled only on the accept edge; later changes have no effect.
- Arithmetic:
  - MEAL/SPECIAL: if bal >= cost, bal - cost with status OK. Otherwise INSUFFICIENT, with no write and the unchanged balance returned.
  - RECHARGE: compute a BAL_W+1-bit sum. If sum > MAX_BAL, write MAX_BAL with status CLIPPED; else write the sum with status OK. A recharge of 0 is OK with an unchanged value; the write still counts.
  - QUERY: status OK, no write, current balance returned.
- Boundaries:
  - req_user >= NUM_USERS → BAL_W-bit BAD_USER handling: no read, no write, resp_balance 0, still a full FSM pass.
  - Balance exactly equal to cost → OK, result 0.
  - Balance already at MAX_BAL with a recharge > 0 → CLIPPED at MAX_BAL.
  - Reset asserted in any state, including mid-EXEC → immediate return to reset values. No partial write survives.

Decomposition:
- Package mess_credit_pkg holds the action codes, status codes, state encoding and a deduct-cost lookup function.
- Sub-module credit_bank: NUM_USERS x BAL_W register file with one combinational read port, one synchronous write port and async reset to INIT_BAL.
- The FSM, arithmetic and counters stay in mess_credit_controller.

Test Plan:
All scenarios use the default parameters except T5, which overrides NUM_USERS = 3.
- T1: reset, then QUERY user 2 → resp 3 cycles after accept with status 00, balance 100, txn_count 0.
- T2: MEAL x4 on user 1 → balances 70, 40, 10 with OK each time. The 4th returns INSUFFICIENT, balance 10; txn_count 3.
- T3: RECHARGE user 0 by 150 → CLIPPED, balance 200. Then SPECIAL → OK, 150. Then RECHARGE 0 → OK, 150, txn_count +1.
- T4: req_valid held high continuously with HOLD_CYCLES=2 → accepts exactly every 6 cycles. req_ready is low in LOOKUP through HOLD, and input changes after accept are ignored.
- T5: NUM_USERS=3, request user 3 → BAD_USER, resp_balance 0, no bank change on users 0-2, txn_count unchanged.
- T6: assert rst during EXEC of a MEAL on user 2 → next-cycle outputs at reset values. QUERY user 2 after release returns 100.
